// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT_W-bit slice walks the operands
// LSB first and drops the final sum/carry/overflow into held result registers.
module serial_adder #(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  psum_q, psum_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    // Slice signals for the digit currently at the bottom of the operand shifters
    logic [DIGIT_W:0]   slice;
    logic [DIGIT_W-1:0] dig;
    logic               slice_co;
    logic               c_into_msb;
    logic [WIDTH-1:0]   psum_next;

    // Adder slice: carry into the digit's top bit is recovered from its sum bit
    always_comb begin
        slice      = {1'b0, opa_q[DIGIT_W-1:0]} + {1'b0, opb_q[DIGIT_W-1:0]}
                   + {{DIGIT_W{1'b0}}, carry_q};
        dig        = slice[DIGIT_W-1:0];
        slice_co   = slice[DIGIT_W];
        c_into_msb = dig[DIGIT_W-1] ^ opa_q[DIGIT_W-1] ^ opb_q[DIGIT_W-1];
        psum_next  = (psum_q >> DIGIT_W) | (WIDTH'(dig) << (WIDTH - DIGIT_W));
    end

    // Next-state and datapath updates; results only load on the last digit
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    // subtraction is a + ~b + 1, the +1 entering as the first carry
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d   = opa_q >> DIGIT_W;
                opb_d   = opb_q >> DIGIT_W;
                psum_d  = psum_next;
                carry_d = slice_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    sum_d   = psum_next;
                    cout_d  = slice_co;
                    ovf_d   = c_into_msb ^ slice_co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-bit-digit and a 16-bit/4-bit-digit
// instance, checked every cycle against an arithmetic model plus literals.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st[2];
    logic        sb[2];
    logic [15:0] av[2];
    logic [15:0] bv[2];
    logic        bz[2];
    logic        dn[2];
    logic        co[2];
    logic        ov[2];
    logic [7:0]  s8;
    logic [15:0] s16;

    int tests = 0;
    int fails = 0;

    serial_adder #(.WIDTH(8), .DIGIT_W(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]),
        .busy(bz[0]), .done(dn[0]), .sum(s8), .cout(co[0]), .overflow(ov[0])
    );

    serial_adder #(.WIDTH(16), .DIGIT_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb[1]),
        .a(av[1]), .b(bv[1]),
        .busy(bz[1]), .done(dn[1]), .sum(s16), .cout(co[1]), .overflow(ov[1])
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    int WD[2] = '{8, 16};
    int ND[2] = '{8, 4};

    // Plain integer arithmetic: unsigned wrap for sum/carry, signed range for overflow
    function automatic res_t ref_op(input int w, input int a, input int b, input bit s);
        res_t r;
        int m  = (1 << w) - 1;
        int sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        int sbv = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        int sr = s ? sa - sbv : sa + sbv;
        r.s = 16'((s ? a - b : a + b) & m);
        r.c = s ? (a >= b) : ((a + b) > m);
        r.o = (sr > (m >> 1)) || (sr < -(1 << (w - 1)));
        return r;
    endfunction

    function automatic int msk(input int d, input logic [15:0] v);
        return (d == 0) ? int'(v[7:0]) : int'(v);
    endfunction

    bit   m_busy[2];
    bit   m_done[2];
    int   m_cnt[2];
    res_t p_res[2];
    res_t e_res[2];

    // Model: an accepted start yields its result N edges later, then one done cycle
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d] <= 1'b0;
                m_done[d] <= 1'b0;
                m_cnt[d]  <= 0;
                e_res[d]  <= '0;
                p_res[d]  <= '0;
            end else if (m_busy[d]) begin
                m_cnt[d] <= m_cnt[d] - 1;
                if (m_cnt[d] == 1) begin
                    m_busy[d] <= 1'b0;
                    m_done[d] <= 1'b1;
                    e_res[d]  <= p_res[d];
                end
            end else begin
                m_done[d] <= 1'b0;
                if (st[d]) begin
                    p_res[d]  <= ref_op(WD[d], msk(d, av[d]), msk(d, bv[d]), sb[d]);
                    m_busy[d] <= 1'b1;
                    m_cnt[d]  <= ND[d];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model each cycle
    always @(negedge clk) begin
        chk("busy8", 32'(bz[0]), 32'(m_busy[0]));
        chk("done8", 32'(dn[0]), 32'(m_done[0]));
        chk("sum8", 32'(s8), 32'(e_res[0].s));
        chk("cout8", 32'(co[0]), 32'(e_res[0].c));
        chk("ovf8", 32'(ov[0]), 32'(e_res[0].o));
        chk("busy16", 32'(bz[1]), 32'(m_busy[1]));
        chk("done16", 32'(dn[1]), 32'(m_done[1]));
        chk("sum16", 32'(s16), 32'(e_res[1].s));
        chk("cout16", 32'(co[1]), 32'(e_res[1].c));
        chk("ovf16", 32'(ov[1]), 32'(e_res[1].o));
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int d, output int cyc);
        cyc = 1;
        while (!dn[d] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!dn[d]) begin
            tests++;
            fails++;
            $display("FAIL done_timeout dut%0d: no done within %0d cycles", d, cyc);
        end
    endtask

    // Issue at the current negedge, scramble inputs after the start edge, wait for done
    task automatic run_op(input int d, input int a, input int b, input bit s, output int cyc);
        st[d] = 1'b1;
        av[d] = 16'(a);
        bv[d] = 16'(b);
        sb[d] = s;
        @(negedge clk);
        st[d] = 1'b0;
        av[d] = 16'($urandom);
        bv[d] = 16'($urandom);
        sb[d] = 1'($urandom);
        wait_done(d, cyc);
    endtask

    task automatic lit8(input string nm, input int a, input int b, input bit s,
                        input int es, input bit ec, input bit eo);
        int cyc;
        run_op(0, a, b, s, cyc);
        chk({nm, "_lat"}, 32'(cyc), 32'd9);
        chk({nm, "_sum"}, 32'(s8), 32'(es));
        chk({nm, "_cout"}, 32'(co[0]), 32'(ec));
        chk({nm, "_ovf"}, 32'(ov[0]), 32'(eo));
        @(negedge clk);
    endtask

    task automatic lit16(input string nm, input int a, input int b, input bit s,
                         input int es, input bit ec, input bit eo);
        int cyc;
        run_op(1, a, b, s, cyc);
        chk({nm, "_lat"}, 32'(cyc), 32'd5);
        chk({nm, "_sum"}, 32'(s16), 32'(es));
        chk({nm, "_cout"}, 32'(co[1]), 32'(ec));
        chk({nm, "_ovf"}, 32'(ov[1]), 32'(eo));
        @(negedge clk);
    endtask

    initial begin
        int cyc, bcyc;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; sb[d] = 1'b0; av[d] = '0; bv[d] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bz[0]), 32'd0);
        chk("rst_done", 32'(dn[0]), 32'd0);
        chk("rst_sum", 32'(s8), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // latency and busy width for the first operation
        st[0] = 1'b1; av[0] = 16'h3C; bv[0] = 16'h0F; sb[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        cyc = 1; bcyc = 0;
        while (!dn[0] && cyc < 40) begin
            if (bz[0]) bcyc++;
            @(negedge clk);
            cyc++;
        end
        chk("first_lat", 32'(cyc), 32'd9);
        chk("first_busy_cycles", 32'(bcyc), 32'd8);
        chk("first_sum", 32'(s8), 32'h4B);
        chk("first_cout", 32'(co[0]), 32'd0);
        @(negedge clk);

        lit8("ff_p_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        lit8("7f_p_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        lit8("05_m_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        lit8("80_m_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        lit8("ff_p_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);
        lit8("00_m_00", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

        // start during RUN is ignored; start in the DONE cycle chains directly
        st[0] = 1'b1; av[0] = 16'h10; bv[0] = 16'h20; sb[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        st[0] = 1'b1; av[0] = 16'hAA; bv[0] = 16'h55;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, cyc);
        chk("ignore_sum", 32'(s8), 32'h30);
        run_op(0, 1, 1, 1'b0, cyc);
        chk("chain_lat", 32'(cyc), 32'd9);
        chk("chain_sum", 32'(s8), 32'h02);
        @(negedge clk);

        // asynchronous abort mid-operation
        st[0] = 1'b1; av[0] = 16'h44; bv[0] = 16'h11; sb[0] = 1'b0;
        repeat (4) @(negedge clk);
        st[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bz[0]), 32'd0);
        chk("abort_done", 32'(dn[0]), 32'd0);
        chk("abort_sum", 32'(s8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        lit8("post_abort", 8'h21, 8'h13, 1'b0, 8'h34, 1'b0, 1'b0);

        // wide instance with multi-bit digits
        lit16("ffff_p_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        lit16("8000_m_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        lit16("0_m_0", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        lit16("7fff_p_7fff", 16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1);

        // randomized regression, checked by the per-cycle compare against the model
        for (int i = 0; i < 1000; i++) begin
            run_op(1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                   1'($urandom), cyc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 300; i++) begin
            run_op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   1'($urandom), cyc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
